// File: rtl/sap_sequencer.sv
// SAP-style control sequencer: one-hot T-state ring, fixed 3-step fetch, per-opcode execute microcode.
// Define SAP_UCODE_WR_EN to make the microcode table writable at runtime; otherwise it is a constant ROM.
module sap_sequencer #(
  parameter int              OPW    = 4,
  parameter int              CW     = 12,
  parameter int              NT     = 6,
  parameter logic [CW-1:0]   F1_CW  = 12'h5E3,
  parameter logic [CW-1:0]   F2_CW  = 12'hBE3,
  parameter logic [CW-1:0]   F3_CW  = 12'h263,
  parameter logic [CW-1:0]   NOP_CW = 12'h3E3,
  parameter logic [OPW-1:0]  HLT_OP = 4'hF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [OPW-1:0]                 ir_out,
  input  logic                           step_mode,
  input  logic                           step,
  input  logic                           ucode_we,
  input  logic [OPW+$clog2(NT-3)-1:0]    ucode_addr,
  input  logic [CW:0]                    ucode_wdata,
  output logic [CW-1:0]                  controlword,
  output logic [NT-1:0]                  t_state,
  output logic                           instr_done,
  output logic                           halted
);

  localparam int NS  = NT - 3;
  localparam int SW  = $clog2(NS);
  localparam int TBL = (2 ** OPW) * NS;
  localparam int IW  = (TBL > 1) ? $clog2(TBL) : 1;

  // Entry format is {last, cw}; steps beyond the third are idle and terminate the instruction.
  function automatic logic [CW:0] default_entry(input int op, input int st);
    logic [CW:0] e;
    e = (st < 3) ? {1'b1, CW'(12'h3E3)} : {1'b1, NOP_CW};
    case (op)
      0: case (st)
           0: e = {1'b0, CW'(12'h1A3)};
           1: e = {1'b1, CW'(12'h2C3)};
           default: ;
         endcase
      1: case (st)
           0: e = {1'b0, CW'(12'h1A3)};
           1: e = {1'b0, CW'(12'h2E1)};
           2: e = {1'b1, CW'(12'h3C7)};
           default: ;
         endcase
      2: case (st)
           0: e = {1'b0, CW'(12'h1A3)};
           1: e = {1'b0, CW'(12'h2E1)};
           2: e = {1'b1, CW'(12'h2CF)};
           default: ;
         endcase
      14: if (st == 0) e = {1'b1, CW'(12'h3F2)};
      default: ;
    endcase
    return e;
  endfunction

  logic [NT-1:0] t_q, t_d;
  logic          halted_q, halted_d;
  int            k;
  logic [CW:0]   rd_entry;
  logic [CW:0]   cur_entry;
  logic          adv, wrap, hlt_t4;

  // k is the 1-based index of the active T-state (0 only before the first reset).
  always_comb begin
    k = 0;
    for (int i = 0; i < NT; i++) begin
      if (t_q[i]) k = i + 1;
    end
  end

`ifdef SAP_UCODE_WR_EN
  logic [CW:0]   table_q [TBL];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  int            wr_op, wr_step;
  logic          wr_ok;

  assign rd_idx   = IW'(int'(ir_out) * NS + k - 4);
  assign rd_entry = table_q[rd_idx];

  always_comb begin
    wr_step = int'(ucode_addr) % (2 ** SW);
    wr_op   = int'(ucode_addr) / (2 ** SW);
    wr_ok   = (wr_step < NS);
    wr_idx  = IW'(wr_op * NS + wr_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL; i++) table_q[IW'(i)] <= default_entry(i / NS, i % NS);
    end else if (ucode_we && wr_ok) begin
      table_q[wr_idx] <= ucode_wdata;
    end
  end
`else
  logic unused_ucode;
  assign unused_ucode = ^{ucode_we, ucode_addr, ucode_wdata};

  always_comb begin
    rd_entry = default_entry(int'(ir_out), k - 4);
  end
`endif

  always_comb begin
    cur_entry = {1'b1, NOP_CW};
    if (k >= 4) cur_entry = rd_entry;
    adv      = !halted_q && (!step_mode || step);
    hlt_t4   = (k == 4) && (ir_out == HLT_OP);
    wrap     = ((k >= 4) && cur_entry[CW]) || (k == NT);
    t_d      = t_q;
    halted_d = halted_q;
    // A halt parks the ring on T4 rather than wrapping.
    if (adv) begin
      if (hlt_t4)    halted_d = 1'b1;
      else if (wrap) t_d = NT'(1);
      else           t_d = {t_q[NT-2:0], 1'b0};
    end

    if (k == 1)      controlword = F1_CW;
    else if (k == 2) controlword = F2_CW;
    else if (k == 3) controlword = F3_CW;
    else             controlword = cur_entry[CW-1:0];
    if (rst || halted_q || hlt_t4) controlword = NOP_CW;

    instr_done = adv && (t_d == NT'(1)) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= NT'(1);
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign t_state = t_q;
  assign halted  = halted_q;

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
Parametrised successor to the SAP hardwired controller. It contains its own one-hot T-state ring counter and a 3-step fixed fetch sequence. A per-opcode execute microcode table supports variable-length instructions with early return to T1. It also provides sticky HLT, single-step run control, and an optional runtime-writable microcode store. It sits between the instruction register and the datapath and drives the control word. It does not generate the clock.

Parameters:
- OPW, 4: opcode width (ir_out).
- CW, 12: control word width.
- NT, 6: number of T-states (>=4). Execute steps per opcode: NS = NT-3.
- F1_CW, 12'h5E3: T1 fetch word.
- F2_CW, 12'hBE3: T2 fetch word.
- F3_CW, 12'h263: T3 fetch word.
- NOP_CW, 12'h3E3: idle/halt word.
- HLT_OP, 4'hF: halt opcode.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ir_out  in  OPW  current opcode from the instruction register.
- step_mode  in  1  1 = advance only on step.
- step  in  1  advance enable in step mode (level, sampled each posedge).
- ucode_we  in  1  microcode write strobe.
- ucode_addr  in  OPW+clog2(NS)  write address {opcode, step}.
- ucode_wdata  in  CW+1  write data {last, cw}.
- controlword  out  CW  control word for the current T-state.
- t_state  out  NT  one-hot T-state, bit0 = T1.
- instr_done  out  1  high during the final T-state of each instruction when advancing.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (posedge with rst=1): t_state=1 (T1), halted=0, microcode table reloaded to defaults. controlword=NOP_CW and instr_done=0 while rst is high. A reset mid-instruction aborts it, and the next cycle is T1.
- adv = !halted & (!step_mode | step).
- On adv, t_state rotates left by one. It wraps to T1 instead when either condition holds:
  - current state is Tk with k>=4 and table[{ir_out,k-4}].last=1;
  - current state is TNT.
- With adv=0, t_state holds.
- controlword is combinational from t_state, ir_out and the table:
  - T1/T2/T3 -> F1_CW/F2_CW/F3_CW.
  - Tk (k>=4) -> table[{ir_out,k-4}].cw.
  - halted=1 -> NOP_CW regardless.
- instr_done = adv & (next state is T1).
- HLT:
  - In T4 with ir_out==HLT_OP, controlword=NOP_CW.
  - If adv, halted is set at that edge and t_state stays at T4.
  - halted is cleared only by rst.
- ir_out must be stable from T4 to the end of the instruction; it is sampled combinationally each cycle.
- Default table, entries {last,cw}, step0/1/2:
  - op0 LDA: {0,1A3} {1,2C3} {1,3E3}
  - op1 ADD: {0,1A3} {0,2E1} {1,3C7}
  - op2 SUB: {0,1A3} {0,2E1} {1,2CF}
  - opE OUT: {1,3F2} {1,3E3} {1,3E3}
  - opF HLT and all other opcodes: {1,3E3} at every step.
  - When NS>3, all extra steps are {1,NOP_CW}.
- Microcode write:
  - At a posedge with ucode_we=1 and rst=0, the addressed entry is updated.
  - The new value is visible to controlword from the next cycle, including when the entry is currently in use.
  - Writes to out-of-range step indices are ignored.
  - If rst and ucode_we are both high, rst wins.

Optional Feature:
SAP_UCODE_WR_EN:
- Defined: the microcode write port is functional as above.
- Undefined: the ucode_* ports are present but ignored, and the table is the constant default set (no storage flops).

Test Plan:
1. rst, ir_out=0, free-run -> controlword 5E3,BE3,263,1A3,2C3, then 5E3. instr_done high in the 5th cycle only. t_state 1,2,4,8,16,1.
2. ir_out=1 (ADD) then ir_out=2 (SUB) -> 6-cycle sequences ending 3C7 and 2CF respectively. ir_out=E -> 4 cycles with 3F2 at T4, then T1.
3. ir_out=F -> reaching T4: controlword 3E3, halted=1 next cycle, t_state frozen at 8 for 20 cycles. rst -> T1 with halted=0.
4. step_mode=1, step=0 for 10 cycles -> t_state frozen. Three single-cycle step pulses -> exactly three advances. Switching step_mode=0 -> free-run resumes.
5. rst asserted while in T5 of ADD -> next cycle t_state=1, controlword=5E3.
6. Macro on: write addr {3,0}=data {1,123}, execute op3 -> T4 controlword 123, then T1. Macro off: same stimulus -> T4 controlword 3E3.
